// File: rtl/matrix_key_emulator.sv
`default_nettype none
// ============================================================================
// Module      : matrix_key_emulator
// Description : Synthesisable stand-in for a 4x4 key matrix. Answers an
//               active-low row drive with the active-low column pattern of
//               the currently closed contacts. Keys are pressed and released
//               on command, with LFSR-modelled contact bounce on each edge
//               and optional timed auto-release. Key k = 4*r + c.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               row[3:0]            - scanner row drive, active low
//               col[3:0]            - emulated column sense, active low, registered
//               cmd_valid/cmd_ready - command handshake (ready only in IDLE)
//               cmd_key[3:0]        - key index 0..15
//               cmd_press           - 1 = press, 0 = release
//               cmd_hold_ms[7:0]    - press only: auto-release after N ms (0 = hold)
//               key_state[15:0]     - settled key state, 1 = pressed
//               busy                - command in progress
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_key_emulator #(
    parameter int          CNT_1MS   = 12000,
    parameter int          BOUNCE_MS = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic        cmd_press,
    input  logic [7:0]  cmd_hold_ms,
    output logic [15:0] key_state,
    output logic        busy
);

    localparam int                c_CW          = (CNT_1MS > 1) ? $clog2(CNT_1MS) : 1;
    localparam logic [c_CW-1:0]   c_CNT_LAST    = c_CW'(CNT_1MS - 1);
    localparam logic [7:0]        c_BOUNCE_LAST = 8'((BOUNCE_MS > 0) ? (BOUNCE_MS - 1) : 0);
    localparam logic              c_CLEAN       = (BOUNCE_MS == 0);
    localparam logic [15:0]       c_TAPS        = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_NOP    = 2'd1,
        ST_BOUNCE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [c_CW-1:0]   r_cnt;        // cycles within the current ms
    logic [7:0]        r_ms;         // ms ticks since entering the current state
    logic [15:0]       r_lfsr;
    logic [15:0]       r_contact;    // raw (possibly bouncing) contact state
    logic [15:0]       r_key_state;  // settled key state
    logic [3:0]        r_key;
    logic              r_target;     // level the bouncing contact settles to
    logic [7:0]        r_hold;
    logic [3:0]        r_col;

    logic              w_accept;
    logic              w_tick;
    logic              w_bounce_done;
    logic              w_hold_done;
    logic              w_state_change;
    logic [3:0]        w_hit;
    logic [15:0]       w_lfsr_next;

    assign w_accept       = cmd_valid & cmd_ready;
    assign w_tick         = (r_cnt == c_CNT_LAST);
    // With clean edges the bounce state lasts exactly one cycle.
    assign w_bounce_done  = c_CLEAN | (w_tick & (r_ms == c_BOUNCE_LAST));
    assign w_hold_done    = w_tick & (r_ms == (r_hold - 8'd1));
    assign w_state_change = (w_state_next != r_state);
    assign w_lfsr_next    = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_TAPS : 16'h0000);

    // Wired matrix: every low row contributes its closed contacts, so several
    // low rows OR together (ghosting) exactly like a real passive matrix.
    always_comb begin
        w_hit = '0;
        for (int r = 0; r < 4; r++) begin
            w_hit = w_hit | ({4{~row[r]}} & r_contact[4*r +: 4]);
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // Target already matches the settled state: no-op command.
                    w_state_next = (cmd_press == r_key_state[cmd_key]) ? ST_NOP : ST_BOUNCE;
                end
            end
            ST_NOP: begin
                w_state_next = ST_IDLE;
            end
            ST_BOUNCE: begin
                if (w_bounce_done) begin
                    w_state_next = (r_target && (r_hold != 8'd0)) ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (w_hold_done) begin
                    w_state_next = ST_BOUNCE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Ready is gated by rst so no command is ever taken during reset.
    assign cmd_ready = (r_state == ST_IDLE) & ~rst;
    assign busy      = (r_state != ST_IDLE);

    // ------------------------------------------------------------------
    // Datapath: timers, LFSR, command latch, contacts, column register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_ms        <= '0;
            r_lfsr      <= LFSR_SEED;
            r_contact   <= '0;
            r_key_state <= '0;
            r_key       <= '0;
            r_target    <= 1'b0;
            r_hold      <= '0;
            r_col       <= 4'hF;
        end else begin
            // Both timers restart on every state entry so each phase is
            // measured from its own start.
            r_cnt <= (w_state_change || w_tick) ? '0 : r_cnt + 1'b1;
            r_ms  <= w_state_change ? '0 : (w_tick ? r_ms + 8'd1 : r_ms);

            if ((r_state == ST_IDLE) && w_accept) begin
                r_key    <= cmd_key;
                r_target <= cmd_press;
                r_hold   <= cmd_hold_ms;
            end

            // Auto-release reuses the bounce state with a low target.
            if ((r_state == ST_HOLD) && w_hold_done) begin
                r_target <= 1'b0;
            end

            if (r_state == ST_BOUNCE) begin
                if (w_tick) begin
                    r_lfsr <= w_lfsr_next;
                end
                if (w_bounce_done) begin
                    r_contact[r_key]   <= r_target;
                    r_key_state[r_key] <= r_target;
                end else if (w_tick) begin
                    r_contact[r_key]   <= r_lfsr[0];
                end
            end

            r_col <= ~w_hit;
        end
    end

    assign col       = r_col;
    assign key_state = r_key_state;

endmodule
`default_nettype wire

// File: tb/tb_matrix_key_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_key_emulator
// Description : Self-checking bench for matrix_key_emulator. Directed
//               sequences and a row/column vector table, followed by random
//               commands and row drives checked against an event-schedule
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_key_emulator;

    localparam int          c_CNT  = 10;
    localparam int          c_BMS  = 2;
    localparam logic [15:0] c_SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_key;
    logic        cmd_press;
    logic [7:0]  cmd_hold_ms;
    logic [15:0] key_state;
    logic        busy;

    int checks = 0;
    int errors = 0;

    matrix_key_emulator #(
        .CNT_1MS   (c_CNT),
        .BOUNCE_MS (c_BMS),
        .LFSR_SEED (c_SEED)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row         (row),
        .col         (col),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_key     (cmd_key),
        .cmd_press   (cmd_press),
        .cmd_hold_ms (cmd_hold_ms),
        .key_state   (key_state),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic issue(input logic [3:0] k, input logic p, input logic [7:0] h);
        cmd_valid   = 1'b1;
        cmd_key     = k;
        cmd_press   = p;
        cmd_hold_ms = h;
        step();
        cmd_valid   = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Reference model: each accepted command is turned into a list of
    // absolute edge numbers at which a contact bounces or settles.
    // ------------------------------------------------------------------
    typedef struct {
        int edge_no;
        int key;
        bit settle;
        bit val;
    } ev_t;

    ev_t         evq[$];
    int          m_n;
    int          m_free;   // first edge after which the emulator is idle again
    bit [15:0]   m_ks;
    bit [15:0]   m_ct;
    bit [15:0]   m_lfsr;
    logic [3:0]  m_col;
    bit          m_acc;

    function automatic bit [15:0] lfsr_step(input bit [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int add_bounce(input int t0, input int k, input bit v);
        ev_t e;
        for (int i = 1; i < c_BMS; i++) begin
            e.edge_no = t0 + c_CNT * i; e.key = k; e.settle = 1'b0; e.val = 1'b0;
            evq.push_back(e);
        end
        e.edge_no = (c_BMS == 0) ? t0 + 1 : t0 + c_CNT * c_BMS;
        e.key = k; e.settle = 1'b1; e.val = v;
        evq.push_back(e);
        return e.edge_no;
    endfunction

    task automatic model_reset();
        evq.delete();
        m_free = m_n;
        m_ks   = '0;
        m_ct   = '0;
        m_lfsr = c_SEED;
        m_col  = 4'hF;
    endtask

    task automatic model_edge();
        logic [3:0] nc;
        bit         hit;
        int         t;
        ev_t        e;
        m_n++;
        m_acc = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            for (int c = 0; c < 4; c++) begin
                hit = 1'b0;
                for (int r = 0; r < 4; r++) begin
                    if (!row[r] && m_ct[4*r+c]) hit = 1'b1;
                end
                nc[c] = !hit;
            end
            if ((m_n - 1 >= m_free) && cmd_valid) begin
                m_acc = 1'b1;
                if (cmd_press == m_ks[cmd_key]) begin
                    m_free = m_n + 1;
                end else begin
                    t = add_bounce(m_n, int'(cmd_key), cmd_press);
                    if (cmd_press && cmd_hold_ms != 8'd0) begin
                        t = add_bounce(t + c_CNT * int'(cmd_hold_ms), int'(cmd_key), 1'b0);
                    end
                    m_free = t;
                end
            end
            while (evq.size() > 0 && evq[0].edge_no == m_n) begin
                e = evq.pop_front();
                if (e.settle) begin
                    m_ct[e.key] = e.val;
                    m_ks[e.key] = e.val;
                end else begin
                    m_ct[e.key] = m_lfsr[0];
                end
                m_lfsr = lfsr_step(m_lfsr);
            end
            m_col = nc;
        end
    endtask

    typedef struct {
        logic [3:0] row;
        logic [3:0] col;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n;
        int n2;
        int bad;
        logic [3:0] rv;

        // Keys 1 and 5 pressed: column 1 in rows 0 and 1.
        tbl[0] = '{4'b1111, 4'b1111};
        tbl[1] = '{4'b1110, 4'b1101};
        tbl[2] = '{4'b1101, 4'b1101};
        tbl[3] = '{4'b1100, 4'b1101};
        tbl[4] = '{4'b1011, 4'b1111};
        tbl[5] = '{4'b0111, 4'b1111};
        tbl[6] = '{4'b0000, 4'b1101};

        rst = 1'b1; row = 4'b1110; cmd_valid = 1'b0;
        cmd_key = '0; cmd_press = 1'b0; cmd_hold_ms = '0;
        repeat (3) step();
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_col", col, 4'hF);
        chk("rst_key_state", key_state, 16'h0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", cmd_ready, 1'b1);

        // Press key 6, hold until released.
        issue(4'd6, 1'b1, 8'd0);
        chk("k6_busy", busy, 1'b1);
        chk("k6_ready_low", cmd_ready, 1'b0);
        count_busy(n);
        chk("k6_busy_cycles", n, 20);
        chk("k6_key_state", key_state, 16'h0040);
        chk("k6_ready_back", cmd_ready, 1'b1);
        row = 4'b1101; step();
        chk("k6_col_row1", col, 4'b1011);
        row = 4'b1110; step();
        chk("k6_col_row0", col, 4'hF);

        // Press key 0 with a 3 ms auto-release.
        issue(4'd0, 1'b1, 8'd3);
        n = 0; bad = 0;
        while (!key_state[0] && n < 200) begin
            if (!busy || cmd_ready) bad++;
            step(); n++;
        end
        chk("k0_rise_cycles", n, 20);
        step(); n2 = 1;
        chk("k0_col", col, 4'b1110);
        while (key_state[0] && n2 < 200) begin
            if (!busy || cmd_ready) bad++;
            step(); n2++;
        end
        chk("k0_fall_cycles", n2, 50);
        chk("k0_busy_throughout", bad, 0);
        chk("k0_idle_end", busy, 1'b0);

        // Release key 6.
        issue(4'd6, 1'b0, 8'd0);
        count_busy(n);
        chk("k6_rel_cycles", n, 20);
        chk("k6_rel_state", key_state, 16'h0000);

        // Press key 1 with a second command held valid while busy.
        issue(4'd1, 1'b1, 8'd0);
        cmd_valid = 1'b1; cmd_key = 4'd5; cmd_press = 1'b1; cmd_hold_ms = 8'd0;
        n = 0; bad = 0;
        while (busy && n < 200) begin
            if (cmd_ready) bad++;
            step(); n++;
        end
        chk("k1_busy_cycles", n, 20);
        chk("k1_no_ready_busy", bad, 0);
        chk("k1_state", key_state, 16'h0002);
        step();
        cmd_valid = 1'b0;
        chk("k5_taken_on_idle", busy, 1'b1);
        chk("k5_not_yet", key_state, 16'h0002);
        count_busy(n);
        chk("k5_busy_cycles", n, 20);
        chk("k5_state", key_state, 16'h0022);

        // Redundant press: one-cycle no-op.
        issue(4'd5, 1'b1, 8'd0);
        chk("nop_busy", busy, 1'b1);
        count_busy(n);
        chk("nop_cycles", n, 1);
        chk("nop_state", key_state, 16'h0022);

        for (int i = 0; i < 7; i++) begin
            row = tbl[i].row;
            step();
            chk($sformatf("tbl_col[%0d]", i), col, tbl[i].col);
        end

        // Reset in the middle of a hold of key 9.
        row = 4'b1011;
        issue(4'd9, 1'b1, 8'd5);
        n = 0;
        while (!key_state[9] && n < 200) begin
            step(); n++;
        end
        chk("k9_rise_cycles", n, 20);
        repeat (3) step();
        chk("k9_col", col, 4'b1101);
        chk("k9_holding", busy, 1'b1);
        rst = 1'b1; step();
        chk("k9_rst_state", key_state, 16'h0);
        chk("k9_rst_col", col, 4'hF);
        chk("k9_rst_busy", busy, 1'b0);
        chk("k9_rst_ready", cmd_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("k9_ready_after", cmd_ready, 1'b1);

        // Random phase against the reference model (starts from reset state,
        // so any stale LFSR value shows up as a bounce mismatch).
        m_n = 0;
        model_reset();
        m_acc = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (m_acc) cmd_valid = 1'b0;
            rst = ($urandom_range(0, 299) == 0);
            if (!cmd_valid && $urandom_range(0, 3) == 0) begin
                cmd_valid   = 1'b1;
                cmd_key     = 4'($urandom_range(0, 15));
                cmd_press   = 1'($urandom_range(0, 1));
                cmd_hold_ms = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
            end
            if ($urandom_range(0, 3) == 0) begin
                rv = 4'($urandom_range(0, 15));
            end else begin
                rv = 4'b0001 << $urandom_range(0, 3);
                rv = ~rv;
            end
            row = rv;
            @(posedge clk);
            model_edge();
            #1;
            chk("rnd_col", col, m_col);
            chk("rnd_key_state", key_state, m_ks);
            chk("rnd_busy", busy, (m_n < m_free));
            chk("rnd_ready", cmd_ready, (m_n >= m_free) && !rst);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
